game_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 31 +++
 rtl/game_sequencer_if.sv | 35 +++
 rtl/frame_divider.sv | 36 +++
 rtl/game_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state indices, BCD width and BCD saturating increment
package game_pkg;

    localparam int S_INITIAL = 0;
    localparam int S_READY   = 1;
    localparam int S_RUN     = 2;
    localparam int S_LOSE    = 3;

    localparam int BCD_W = 8;

    typedef enum logic [1:0] {
        ST_INITIAL = 2'd0,
        ST_READY   = 2'd1,
        ST_RUN     = 2'd2,
        ST_LOSE    = 2'd3
    } state_e;

    // Two-digit BCD increment that sticks at 99; also used by the score display
    function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - button, sync, datapath and display signals of the sequencer
interface game_sequencer_if;

    logic       Start;
    logic       Ack;
    logic       Jump;
    logic       V_Sync;
    logic       Collide;
    logic       Pipe_Passed;

    logic       Q_Initial;
    logic       Q_Ready;
    logic       Q_Run;
    logic       Q_Lose;
    logic       Pipe_Step;
    logic       Phys_Step;
    logic       Jump_Req;
    logic [3:0] Countdown;
    logic [7:0] Score;
    logic [7:0] High_Score;
    logic       New_High;

    modport slave (
        input  Start, Ack, Jump, V_Sync, Collide, Pipe_Passed,
        output Q_Initial, Q_Ready, Q_Run, Q_Lose, Pipe_Step, Phys_Step,
               Jump_Req, Countdown, Score, High_Score, New_High
    );

    modport master (
        output Start, Ack, Jump, V_Sync, Collide, Pipe_Passed,
        input  Q_Initial, Q_Ready, Q_Run, Q_Lose, Pipe_Step, Phys_Step,
               Jump_Req, Countdown, Score, High_Score, New_High
    );

endinterface

// File: rtl/frame_divider.sv
// rtl/frame_divider.sv - counts frame ticks and flags every DIV-th one
module frame_divider #(
    parameter int DIV = 2,
    parameter int W   = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic step
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // step is the wrap condition; the parent registers it alongside its other outputs
    always_comb begin
        step  = tick && !clr && (cnt_q == W'(DIV - 1));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = step ? '0 : cnt_q + W'(1);
        end
    end

    // Tick counter register
    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game state machine, frame step enables, jump queue and scoring
module game_sequencer
    import game_pkg::*;
#(
    parameter int PIPE_DIV   = 2,
    parameter int PHYS_DIV   = 1,
    parameter int SEC_FRAMES = 60
) (
    input logic             Clk,
    input logic             reset,
    game_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [3:0]       onehot_q, onehot_d;
    logic             v_q;
    logic [7:0]       sec_q, sec_d;
    logic [3:0]       cd_q, cd_d;
    logic [BCD_W-1:0] score_q, score_d;
    logic [BCD_W-1:0] hs_q, hs_d;
    logic             nh_q, nh_d;
    logic             jp_q, jp_d;
    logic             jr_q, jr_d;
    logic             pipe_step_q, pipe_step_d;
    logic             phys_step_q, phys_step_d;

    logic tick;
    logic in_run;
    logic div_clr;
    logic div_tick;
    logic pipe_wrap;
    logic phys_wrap;

    assign tick     = v_q & ~bus.V_Sync;
    assign in_run   = (state_q == ST_RUN);
    assign div_clr  = ~in_run;
    assign div_tick = in_run & tick & ~bus.Collide;

    frame_divider #(.DIV(PIPE_DIV), .W(4)) u_pipe_div (
        .Clk   (Clk),
        .reset (reset),
        .clr   (div_clr),
        .tick  (div_tick),
        .step  (pipe_wrap)
    );

    frame_divider #(.DIV(PHYS_DIV), .W(4)) u_phys_div (
        .Clk   (Clk),
        .reset (reset),
        .clr   (div_clr),
        .tick  (div_tick),
        .step  (phys_wrap)
    );

    // Next state, countdown, jump queue, step enables and score bookkeeping
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        cd_d        = cd_q;
        score_d     = score_q;
        hs_d        = hs_q;
        nh_d        = nh_q;
        jp_d        = jp_q;
        jr_d        = 1'b0;
        pipe_step_d = 1'b0;
        phys_step_d = 1'b0;

        case (state_q)
            ST_INITIAL: begin
                if (bus.Start) begin
                    state_d = ST_READY;
                    score_d = '0;
                    cd_d    = 4'd3;
                    sec_d   = '0;
                end
            end

            ST_READY: begin
                if (bus.Ack) begin
                    state_d = ST_INITIAL;
                    cd_d    = 4'd0;
                    sec_d   = '0;
                end else if (tick) begin
                    if (sec_q == 8'(SEC_FRAMES - 1)) begin
                        sec_d = '0;
                        if (cd_q == 4'd1) begin
                            state_d = ST_RUN;
                            cd_d    = 4'd0;
                            jp_d    = 1'b0;
                        end else begin
                            cd_d = cd_q - 4'd1;
                        end
                    end else begin
                        sec_d = sec_q + 8'd1;
                    end
                end
            end

            ST_RUN: begin
                if (bus.Collide) begin
                    // Collision wins: no steps, no jump, no score on this cycle
                    state_d = ST_LOSE;
                    jp_d    = 1'b0;
                end else begin
                    pipe_step_d = pipe_wrap;
                    phys_step_d = phys_wrap;
                    if (phys_wrap) begin
                        jr_d = jp_q | bus.Jump;
                        jp_d = 1'b0;
                    end else if (bus.Jump) begin
                        jp_d = 1'b1;
                    end
                    if (bus.Pipe_Passed) begin
                        score_d = bcd_inc_sat(score_q);
                    end
                end
            end

            ST_LOSE: begin
                // Unsigned compare is valid for packed BCD; after the update the values match
                if (score_q > hs_q) begin
                    hs_d = score_q;
                    nh_d = 1'b1;
                end
                if (bus.Ack) begin
                    state_d = ST_INITIAL;
                    nh_d    = 1'b0;
                end
            end

            default: begin
                state_d = ST_INITIAL;
            end
        endcase

        onehot_d = 4'b0001 << state_d;
    end

    // All state and output registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= ST_INITIAL;
            onehot_q    <= 4'b0001;
            v_q         <= 1'b0;
            sec_q       <= '0;
            cd_q        <= '0;
            score_q     <= '0;
            hs_q        <= '0;
            nh_q        <= 1'b0;
            jp_q        <= 1'b0;
            jr_q        <= 1'b0;
            pipe_step_q <= 1'b0;
            phys_step_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            onehot_q    <= onehot_d;
            v_q         <= bus.V_Sync;
            sec_q       <= sec_d;
            cd_q        <= cd_d;
            score_q     <= score_d;
            hs_q        <= hs_d;
            nh_q        <= nh_d;
            jp_q        <= jp_d;
            jr_q        <= jr_d;
            pipe_step_q <= pipe_step_d;
            phys_step_q <= phys_step_d;
        end
    end

    assign bus.Q_Initial  = onehot_q[S_INITIAL];
    assign bus.Q_Ready    = onehot_q[S_READY];
    assign bus.Q_Run      = onehot_q[S_RUN];
    assign bus.Q_Lose     = onehot_q[S_LOSE];
    assign bus.Pipe_Step  = pipe_step_q;
    assign bus.Phys_Step  = phys_step_q;
    assign bus.Jump_Req   = jr_q;
    assign bus.Countdown  = cd_q;
    assign bus.Score      = score_q;
    assign bus.High_Score = hs_q;
    assign bus.New_High   = nh_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    game_sequencer_if bus ();

    game_sequencer #(.PIPE_DIV(2), .PHYS_DIV(1), .SEC_FRAMES(4)) dut (
        .Clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_idle();
        bus.V_Sync = 1'b0;
        cycle();
        bus.V_Sync = 1'b1;
        cycle();
    endtask

    task automatic go_run();
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        repeat (12) tick_idle();
    endtask

    task automatic pulse_pp(input int n);
        repeat (n) begin
            bus.Pipe_Passed = 1'b1;
            cycle();
        end
        bus.Pipe_Passed = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        checks++;
        if ({bus.Q_Lose, bus.Q_Run, bus.Q_Ready, bus.Q_Initial} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state got %b want 0001", {bus.Q_Lose, bus.Q_Run, bus.Q_Ready, bus.Q_Initial});
        end
        checks++;
        if ({bus.Score, bus.High_Score, bus.Countdown, bus.New_High, bus.Pipe_Step, bus.Phys_Step, bus.Jump_Req} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {bus.Score, bus.High_Score, bus.Countdown, bus.New_High, bus.Pipe_Step, bus.Phys_Step, bus.Jump_Req});
        end
    endtask

    task automatic test_countdown();
        bus.Ack = 1'b1;
        cycle();
        bus.Ack = 1'b0;
        checks++;
        if (bus.Q_Initial !== 1'b1) begin
            errors++;
            $display("FAIL ack_in_initial got %b want 1", bus.Q_Initial);
        end
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        checks++;
        if (bus.Q_Ready !== 1'b1 || bus.Countdown !== 4'd3) begin
            errors++;
            $display("FAIL start_to_ready got %b/%0d want 1/3", bus.Q_Ready, bus.Countdown);
        end
        for (int k = 1; k <= 12; k++) begin
            bus.V_Sync = 1'b0;
            cycle();
            bus.V_Sync = 1'b1;
            checks++;
            if (k < 12) begin
                if (bus.Q_Ready !== 1'b1 || bus.Countdown !== 4'(3 - k / 4)) begin
                    errors++;
                    $display("FAIL countdown_tick%0d got %b/%0d want 1/%0d", k, bus.Q_Ready, bus.Countdown, 3 - k / 4);
                end
            end else begin
                if (bus.Q_Run !== 1'b1 || bus.Countdown !== 4'd0) begin
                    errors++;
                    $display("FAIL run_entry got %b/%0d want 1/0", bus.Q_Run, bus.Countdown);
                end
            end
            cycle();
        end
    endtask

    task automatic test_steps();
        int pipes;
        int phys;
        pipes = 0;
        phys  = 0;
        for (int k = 1; k <= 6; k++) begin
            bus.V_Sync = 1'b0;
            cycle();
            bus.V_Sync = 1'b1;
            pipes += int'(bus.Pipe_Step);
            phys  += int'(bus.Phys_Step);
            checks++;
            if (bus.Pipe_Step !== ((k % 2) == 0) || bus.Phys_Step !== 1'b1) begin
                errors++;
                $display("FAIL step_tick%0d got pipe %b phys %b want %b 1", k, bus.Pipe_Step, bus.Phys_Step, (k % 2) == 0);
            end
            cycle();
            checks++;
            if (bus.Pipe_Step !== 1'b0 || bus.Phys_Step !== 1'b0) begin
                errors++;
                $display("FAIL step_width%0d got pipe %b phys %b want 0 0", k, bus.Pipe_Step, bus.Phys_Step);
            end
        end
        checks++;
        if (pipes != 3 || phys != 6) begin
            errors++;
            $display("FAIL step_counts got %0d/%0d want 3/6", pipes, phys);
        end
    endtask

    task automatic test_jump();
        repeat (3) begin
            bus.Jump = 1'b1;
            cycle();
            bus.Jump = 1'b0;
            checks++;
            if (bus.Jump_Req !== 1'b0) begin
                errors++;
                $display("FAIL jump_early got %b want 0", bus.Jump_Req);
            end
            cycle();
        end
        bus.V_Sync = 1'b0;
        cycle();
        bus.V_Sync = 1'b1;
        checks++;
        if (bus.Jump_Req !== 1'b1 || bus.Phys_Step !== 1'b1) begin
            errors++;
            $display("FAIL jump_collapsed got %b/%b want 1/1", bus.Jump_Req, bus.Phys_Step);
        end
        cycle();
        bus.V_Sync = 1'b0;
        cycle();
        bus.V_Sync = 1'b1;
        checks++;
        if (bus.Jump_Req !== 1'b0) begin
            errors++;
            $display("FAIL jump_single got %b want 0", bus.Jump_Req);
        end
        cycle();
        bus.V_Sync = 1'b0;
        bus.Jump   = 1'b1;
        cycle();
        bus.V_Sync = 1'b1;
        bus.Jump   = 1'b0;
        checks++;
        if (bus.Jump_Req !== 1'b1) begin
            errors++;
            $display("FAIL jump_with_tick got %b want 1", bus.Jump_Req);
        end
        cycle();
    endtask

    task automatic test_first_loss();
        pulse_pp(5);
        bus.Collide = 1'b1;
        cycle();
        bus.Collide = 1'b0;
        checks++;
        if (bus.Q_Lose !== 1'b1 || bus.Score !== 8'h05) begin
            errors++;
            $display("FAIL loss1 got %b/%h want 1/05", bus.Q_Lose, bus.Score);
        end
        cycle();
        checks++;
        if (bus.High_Score !== 8'h05 || bus.New_High !== 1'b1) begin
            errors++;
            $display("FAIL loss1_high got %h/%b want 05/1", bus.High_Score, bus.New_High);
        end
        bus.Ack = 1'b1;
        cycle();
        bus.Ack = 1'b0;
        checks++;
        if (bus.Q_Initial !== 1'b1 || bus.New_High !== 1'b0 || bus.High_Score !== 8'h05) begin
            errors++;
            $display("FAIL loss1_ack got %b/%b/%h want 1/0/05", bus.Q_Initial, bus.New_High, bus.High_Score);
        end
    endtask

    task automatic test_collide_priority();
        go_run();
        checks++;
        if (bus.Q_Run !== 1'b1 || bus.Score !== 8'h00) begin
            errors++;
            $display("FAIL game2_start got %b/%h want 1/00", bus.Q_Run, bus.Score);
        end
        pulse_pp(7);
        checks++;
        if (bus.Score !== 8'h07) begin
            errors++;
            $display("FAIL score7 got %h want 07", bus.Score);
        end
        bus.Collide     = 1'b1;
        bus.Pipe_Passed = 1'b1;
        bus.Jump        = 1'b1;
        bus.V_Sync      = 1'b0;
        cycle();
        bus.Collide     = 1'b0;
        bus.Pipe_Passed = 1'b0;
        bus.Jump        = 1'b0;
        bus.V_Sync      = 1'b1;
        checks++;
        if (bus.Q_Lose !== 1'b1 || bus.Q_Run !== 1'b0 || bus.Score !== 8'h07) begin
            errors++;
            $display("FAIL collide_state got %b/%b/%h want 1/0/07", bus.Q_Lose, bus.Q_Run, bus.Score);
        end
        checks++;
        if ({bus.Pipe_Step, bus.Phys_Step, bus.Jump_Req} !== 3'b000 || bus.High_Score !== 8'h05) begin
            errors++;
            $display("FAIL collide_suppress got %b/%h want 000/05", {bus.Pipe_Step, bus.Phys_Step, bus.Jump_Req}, bus.High_Score);
        end
        cycle();
        checks++;
        if (bus.High_Score !== 8'h07 || bus.New_High !== 1'b1) begin
            errors++;
            $display("FAIL new_high got %h/%b want 07/1", bus.High_Score, bus.New_High);
        end
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        checks++;
        if (bus.Q_Lose !== 1'b1) begin
            errors++;
            $display("FAIL start_in_lose got %b want 1", bus.Q_Lose);
        end
        bus.Ack = 1'b1;
        cycle();
        bus.Ack = 1'b0;
        checks++;
        if (bus.Q_Initial !== 1'b1 || bus.New_High !== 1'b0) begin
            errors++;
            $display("FAIL lose_ack got %b/%b want 1/0", bus.Q_Initial, bus.New_High);
        end
    endtask

    task automatic test_score_saturation();
        go_run();
        pulse_pp(9);
        checks++;
        if (bus.Score !== 8'h09) begin
            errors++;
            $display("FAIL score9 got %h want 09", bus.Score);
        end
        pulse_pp(1);
        checks++;
        if (bus.Score !== 8'h10) begin
            errors++;
            $display("FAIL score10 got %h want 10", bus.Score);
        end
        pulse_pp(90);
        checks++;
        if (bus.Score !== 8'h99) begin
            errors++;
            $display("FAIL score100 got %h want 99", bus.Score);
        end
        pulse_pp(3);
        checks++;
        if (bus.Score !== 8'h99) begin
            errors++;
            $display("FAIL score_sat got %h want 99", bus.Score);
        end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if ({bus.Q_Lose, bus.Q_Run, bus.Q_Ready, bus.Q_Initial} !== 4'b0001) begin
            errors++;
            $display("FAIL midrun_reset_state got %b want 0001", {bus.Q_Lose, bus.Q_Run, bus.Q_Ready, bus.Q_Initial});
        end
        checks++;
        if (bus.Score !== 8'h00 || bus.High_Score !== 8'h00 || bus.New_High !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_score got %h/%h/%b want 00/00/0", bus.Score, bus.High_Score, bus.New_High);
        end
    endtask

    task automatic test_ready_abort();
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        repeat (4) tick_idle();
        checks++;
        if (bus.Q_Ready !== 1'b1 || bus.Countdown !== 4'd2) begin
            errors++;
            $display("FAIL ready_cd2 got %b/%0d want 1/2", bus.Q_Ready, bus.Countdown);
        end
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        checks++;
        if (bus.Q_Ready !== 1'b1 || bus.Countdown !== 4'd2) begin
            errors++;
            $display("FAIL start_in_ready got %b/%0d want 1/2", bus.Q_Ready, bus.Countdown);
        end
        bus.Ack = 1'b1;
        cycle();
        bus.Ack = 1'b0;
        checks++;
        if (bus.Q_Initial !== 1'b1 || bus.Countdown !== 4'd0) begin
            errors++;
            $display("FAIL ready_abort got %b/%0d want 1/0", bus.Q_Initial, bus.Countdown);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.Start       = 1'b0;
        bus.Ack         = 1'b0;
        bus.Jump        = 1'b0;
        bus.V_Sync      = 1'b1;
        bus.Collide     = 1'b0;
        bus.Pipe_Passed = 1'b0;
        test_reset();
        test_countdown();
        test_steps();
        test_jump();
        test_first_loss();
        test_collide_priority();
        test_score_saturation();
        test_reset_mid_run();
        test_ready_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
